// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the multi-cycle ARM32 control FSM.
package ctrl_pkg;

   typedef enum logic [3:0] {
      RST, FETCH, FWAIT, DECODE, SHIFT, EXEC, MEM, MWAIT, WB, BR, HALT
   } state_t;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;

   // Opcode classes: DP is opcode[6], MEM/BR are opcode[6:5].
   localparam logic       OPC_DP   = 1'b0;
   localparam logic [1:0] OPC_MEM  = 2'b10;
   localparam logic [1:0] OPC_BR   = 2'b11;
   localparam logic [6:0] OPC_HALT = 7'b1111111;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_RAM = 2'd1;
   localparam logic [1:0] WB_PC  = 2'd2;

   function automatic logic [3:0] cnt_dec(input logic [3:0] c);
      return (c == 4'd0) ? 4'd0 : c - 4'd1;
   endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle controller and the ARM32 datapath.
interface multicycle_ctrl_if;
   logic [6:0] opcode;
   logic [3:0] cond;
   logic       set_flags;
   logic [3:0] status_flags;

   logic       waiting;
   logic       halted;
   logic [1:0] wb_sel;
   logic       sel_A;
   logic       sel_B;
   logic       sel_shift;
   logic       w_en;
   logic       en_A;
   logic       en_B;
   logic       en_C;
   logic       en_S;
   logic [2:0] ALU_op;
   logic       load_ir;
   logic       load_pc;
   logic       clear_pc;
   logic       sel_pc;
   logic       load_addr;
   logic       sel_addr;
   logic       ram_w_en;

   modport master (
      input  opcode, cond, set_flags, status_flags,
      output waiting, halted, wb_sel, sel_A, sel_B, sel_shift, w_en, en_A, en_B,
             en_C, en_S, ALU_op, load_ir, load_pc, clear_pc, sel_pc, load_addr,
             sel_addr, ram_w_en
   );

   modport slave (
      output opcode, cond, set_flags, status_flags,
      input  waiting, halted, wb_sel, sel_A, sel_B, sel_shift, w_en, en_A, en_B,
             en_C, en_S, ALU_op, load_ir, load_pc, clear_pc, sel_pc, load_addr,
             sel_addr, ram_w_en
   );
endinterface

// File: rtl/multicycle_ctrl_cond_eval.sv
// ARM condition-code evaluator: (cond, NZCV) -> pass. 1111 behaves as AL.
module cond_eval
   import ctrl_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] nzcv,
   output logic       pass
);
   logic n, z, c, v;
   assign {n, z, c, v} = nzcv;

   always_comb begin
      pass = 1'b1;
      case (cond)
         COND_EQ: pass = z;
         COND_NE: pass = !z;
         COND_CS: pass = c;
         COND_CC: pass = !c;
         COND_MI: pass = n;
         COND_PL: pass = !n;
         COND_VS: pass = v;
         COND_VC: pass = !v;
         COND_HI: pass = c && !z;
         COND_LS: pass = !c || z;
         COND_GE: pass = (n == v);
         COND_LT: pass = (n != v);
         COND_GT: pass = !z && (n == v);
         COND_LE: pass = z || (n != v);
         COND_AL: pass = 1'b1;
         default: pass = 1'b1;
      endcase
   end
endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle ARM32 control FSM; Moore outputs drive every datapath enable/select.
// Conditional execution is built only when COND_EXEC_EN is defined.
//
// state  | meaning
// RST    | reset, PC cleared
// FETCH  | present PC to RAM, start fetch timer
// FWAIT  | wait for instruction; load IR and PC+4 on terminal count
// DECODE | latch operands, evaluate condition
// SHIFT  | extra operand cycle for register-specified shift
// EXEC   | ALU operation or address/branch-target add
// MEM    | present data address; STR strobes, LDR starts timer
// MWAIT  | wait for load data
// WB     | register-file write
// BR     | load branch target into PC
// HALT   | stopped until reset
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int unsigned MEM_LAT = 2,
   parameter logic [2:0]  ALU_ADD = 3'b100
) (
   input  logic               clk,
   input  logic               rst_n,
   multicycle_ctrl_if.master  bus
);
   localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       cond_pass;
   logic       is_rs, is_dp;

   assign is_rs = (bus.opcode[5:3] == 3'b100);
   assign is_dp = (bus.opcode[6] == OPC_DP);

`ifdef COND_EXEC_EN
   cond_eval u_cond_eval (
      .cond (bus.cond),
      .nzcv (bus.status_flags),
      .pass (cond_pass)
   );
`else
   logic unused_cond;
   assign unused_cond = &{1'b0, bus.cond, bus.status_flags};
   assign cond_pass   = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RST;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      bus.waiting   = 1'b0;
      bus.halted    = 1'b0;
      bus.wb_sel    = WB_ALU;
      bus.sel_A     = 1'b0;
      bus.sel_B     = 1'b0;
      bus.sel_shift = 1'b0;
      bus.w_en      = 1'b0;
      bus.en_A      = 1'b0;
      bus.en_B      = 1'b0;
      bus.en_C      = 1'b0;
      bus.en_S      = 1'b0;
      bus.ALU_op    = 3'b000;
      bus.load_ir   = 1'b0;
      bus.load_pc   = 1'b0;
      bus.clear_pc  = 1'b0;
      bus.sel_pc    = 1'b0;
      bus.load_addr = 1'b0;
      bus.sel_addr  = 1'b0;
      bus.ram_w_en  = 1'b0;

      case (state_q)
         RST: begin
            bus.clear_pc = 1'b1;
            state_d      = FETCH;
         end
         FETCH: begin
            bus.load_addr = 1'b1;
            bus.sel_addr  = 1'b1;
            bus.waiting   = 1'b1;
            cnt_d         = LAT_M1;
            state_d       = FWAIT;
         end
         FWAIT: begin
            bus.waiting = 1'b1;
            cnt_d       = cnt_dec(cnt_q);
            if (cnt_q == 4'd0) begin
               bus.load_ir = 1'b1;
               bus.load_pc = 1'b1;
               state_d     = DECODE;
            end
         end
         DECODE: begin
            bus.en_A      = 1'b1;
            bus.en_B      = 1'b1;
            bus.sel_shift = is_rs;
            // Condition is checked first so a failed HALT is skipped like any other op.
            if (!cond_pass)                  state_d = FETCH;
            else if (bus.opcode == OPC_HALT) state_d = HALT;
            else if (is_rs)                  state_d = SHIFT;
            else                             state_d = EXEC;
         end
         SHIFT: begin
            bus.en_B      = 1'b1;
            bus.sel_shift = 1'b1;
            state_d       = EXEC;
         end
         EXEC: begin
            bus.en_C = 1'b1;
            if (is_dp) begin
               bus.ALU_op = bus.opcode[2:0];
               bus.sel_A  = !is_rs;
               bus.sel_B  = bus.opcode[4];
               bus.en_S   = bus.set_flags;
               state_d    = WB;
            end else begin
               bus.ALU_op = ALU_ADD;
               bus.sel_B  = 1'b1;
               state_d    = (bus.opcode[6:5] == OPC_MEM) ? MEM : BR;
            end
         end
         MEM: begin
            bus.load_addr = 1'b1;
            if (bus.opcode[4]) begin
               bus.ram_w_en = 1'b1;
               state_d      = FETCH;
            end else begin
               cnt_d   = LAT_M1;
               state_d = MWAIT;
            end
         end
         MWAIT: begin
            bus.waiting = 1'b1;
            cnt_d       = cnt_dec(cnt_q);
            if (cnt_q == 4'd0) state_d = WB;
         end
         WB: begin
            bus.w_en   = 1'b1;
            bus.wb_sel = is_dp ? WB_ALU : WB_RAM;
            state_d    = FETCH;
         end
         BR: begin
            bus.load_pc = 1'b1;
            bus.sel_pc  = 1'b1;
            state_d     = FETCH;
         end
         HALT: begin
            bus.halted = 1'b1;
         end
         default: state_d = RST;
      endcase
   end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: three instances with MEM_LAT = 1, 2, 3.
module tb_multicycle_ctrl;
   logic clk = 1'b0;
   logic rst1_n, rst2_n, rst3_n;
   int   n_total = 0;
   int   n_bad   = 0;
   int   n_w     = 0;
   int   n_ram   = 0;
   int   n_wait  = 0;

   always #5 clk = ~clk;

   multicycle_ctrl_if b1();
   multicycle_ctrl_if b2();
   multicycle_ctrl_if b3();

   multicycle_ctrl #(.MEM_LAT(1)) u_dut1 (.clk(clk), .rst_n(rst1_n), .bus(b1));
   multicycle_ctrl #(.MEM_LAT(2)) u_dut2 (.clk(clk), .rst_n(rst2_n), .bus(b2));
   multicycle_ctrl #(.MEM_LAT(3)) u_dut3 (.clk(clk), .rst_n(rst3_n), .bus(b3));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance to the next falling edge and tally strobes across all instances.
   task automatic cyc();
      @(negedge clk);
      n_w    += int'(b1.w_en) + int'(b2.w_en) + int'(b3.w_en);
      n_ram  += int'(b1.ram_w_en) + int'(b2.ram_w_en) + int'(b3.ram_w_en);
      n_wait += int'(b1.waiting) + int'(b2.waiting) + int'(b3.waiting);
   endtask

   task automatic clr();
      n_w = 0; n_ram = 0; n_wait = 0;
   endtask

   task automatic drive2(input logic [6:0] op, input logic [3:0] cnd,
                         input logic sf, input logic [3:0] fl);
      b2.opcode = op; b2.cond = cnd; b2.set_flags = sf; b2.status_flags = fl;
   endtask

   // From FETCH on b2 (MEM_LAT=2): run a plain DP op, expect executed or skipped.
   task automatic dp_run(input string tag, input logic exp_exec);
      repeat (3) cyc();
      check({tag, "_dec_en"}, {b2.en_A, b2.en_B}, 2'b11);
      cyc();
      if (exp_exec) begin
         check({tag, "_exec_enC"}, b2.en_C, 1'b1);
         cyc();
         check({tag, "_wb_wen"}, b2.w_en, 1'b1);
         cyc();
      end else begin
         check({tag, "_skip_enC"}, b2.en_C, 1'b0);
      end
      check({tag, "_back_fetch"}, {b2.waiting, b2.load_addr, b2.sel_addr}, 3'b111);
   endtask

   initial begin
      rst1_n = 1'b0; rst2_n = 1'b0; rst3_n = 1'b0;
      drive2(7'b0011000, 4'b1110, 1'b0, 4'b0000);
      b1.opcode = 7'b0011000; b1.cond = 4'b1110; b1.set_flags = 1'b0; b1.status_flags = 4'b0000;
      b3.opcode = 7'b1001000; b3.cond = 4'b1110; b3.set_flags = 1'b0; b3.status_flags = 4'b0000;
      repeat (2) @(negedge clk);

      // Test 1: reset then DP immediate, MEM_LAT = 2
      check("rst_clear_pc", b2.clear_pc, 1'b1);
      check("rst_strobes", {b2.waiting, b2.w_en, b2.load_pc, b2.load_ir, b2.en_C}, 5'b0);
      rst2_n = 1'b1;
      clr();
      cyc();
      check("t1_fetch", {b2.waiting, b2.load_addr, b2.sel_addr, b2.clear_pc}, 4'b1110);
      cyc();
      check("t1_fwait1", {b2.waiting, b2.load_ir}, 2'b10);
      cyc();
      check("t1_fwait0", {b2.waiting, b2.load_ir, b2.load_pc, b2.sel_pc}, 4'b1110);
      cyc();
      check("t1_decode", {b2.waiting, b2.en_A, b2.en_B, b2.sel_shift}, 4'b0110);
      check("t1_wait_cnt", n_wait, 3);
      cyc();
      check("t1_exec", {b2.en_C, b2.sel_A, b2.sel_B, b2.en_S}, 4'b1110);
      check("t1_exec_op", b2.ALU_op, 3'b000);
      cyc();
      check("t1_wb", {b2.w_en, b2.wb_sel}, 3'b100);
      cyc();
      check("t1_fetch2", {b2.w_en, b2.waiting}, 2'b01);

      // Test 2: SUB reg-shift-reg with S
      drive2(7'b0100001, 4'b1110, 1'b1, 4'b0000);
      repeat (3) cyc();
      check("t2_decode_shift", {b2.en_A, b2.sel_shift}, 2'b11);
      cyc();
      check("t2_shift", {b2.en_A, b2.en_B, b2.sel_shift, b2.en_C}, 4'b0110);
      cyc();
      check("t2_exec", {b2.en_C, b2.sel_A, b2.sel_B, b2.en_S}, 4'b1001);
      check("t2_exec_op", b2.ALU_op, 3'b001);
      cyc();
      check("t2_wb", {b2.w_en, b2.wb_sel}, 3'b100);
      cyc();
      check("t2_fetch", b2.waiting, 1'b1);

      // Test 4: STR, S bit ignored for non-DP
      drive2(7'b1011000, 4'b1110, 1'b1, 4'b0000);
      clr();
      repeat (4) cyc();
      check("t4_exec", {b2.en_C, b2.sel_B, b2.en_S}, 3'b110);
      check("t4_exec_op", b2.ALU_op, 3'b100);
      cyc();
      check("t4_mem", {b2.load_addr, b2.sel_addr, b2.ram_w_en}, 3'b101);
      cyc();
      check("t4_fetch", {b2.waiting, b2.ram_w_en}, 2'b10);
      check("t4_ram_cnt", n_ram, 1);
      check("t4_wen_cnt", n_w, 0);

      // Test 5: condition codes
      drive2(7'b0011000, 4'b0000, 1'b0, 4'b0000);
`ifdef COND_EXEC_EN
      clr();
      dp_run("t5_eq_fail", 1'b0);
      check("t5_eq_fail_wen", n_w, 0);
`else
      dp_run("t5_eq_as_al", 1'b1);
`endif
      drive2(7'b0011000, 4'b0000, 1'b0, 4'b0100);
      dp_run("t5_eq_pass", 1'b1);
      drive2(7'b0011000, 4'b1111, 1'b0, 4'b0000);
      dp_run("t5_nv_as_al", 1'b1);

      // Test 6: branch then HALT
      drive2(7'b1101000, 4'b1110, 1'b0, 4'b0000);
      repeat (4) cyc();
      check("t6_br_exec", {b2.en_C, b2.sel_B, b2.ALU_op}, 5'b11100);
      cyc();
      check("t6_br", {b2.load_pc, b2.sel_pc, b2.w_en}, 3'b110);
      cyc();
      check("t6_br_fetch", {b2.waiting, b2.load_pc}, 2'b10);
      drive2(7'b1111111, 4'b1110, 1'b0, 4'b0000);
      repeat (4) cyc();
      check("t6_halt", {b2.halted, b2.waiting}, 2'b10);
      drive2(7'b0011000, 4'b1110, 1'b0, 4'b0000);
      repeat (5) cyc();
      check("t6_halt_stays", {b2.halted, b2.waiting, b2.load_addr}, 3'b100);
      rst2_n = 1'b0;
      #1;
      check("t6_halt_rst", {b2.halted, b2.clear_pc}, 2'b01);

      // MEM_LAT = 1: single wait cycle before IR load
      @(negedge clk);
      rst1_n = 1'b1;
      cyc();
      check("l1_fetch", b1.waiting, 1'b1);
      cyc();
      check("l1_fwait", {b1.waiting, b1.load_ir}, 2'b11);
      cyc();
      check("l1_decode", {b1.en_A, b1.waiting}, 2'b10);
      repeat (2) cyc();
      check("l1_wb", b1.w_en, 1'b1);
      rst1_n = 1'b0;

      // Test 3: LDR, MEM_LAT = 3
      @(negedge clk);
      rst3_n = 1'b1;
      clr();
      cyc();
      check("t3_fetch", b3.waiting, 1'b1);
      repeat (2) cyc();
      check("t3_fwait_mid", {b3.waiting, b3.load_ir}, 2'b10);
      cyc();
      check("t3_fwait_end", {b3.waiting, b3.load_ir}, 2'b11);
      repeat (2) cyc();
      check("t3_exec", {b3.en_C, b3.sel_A, b3.sel_B, b3.ALU_op}, 6'b101100);
      cyc();
      check("t3_mem", {b3.load_addr, b3.sel_addr, b3.ram_w_en, b3.waiting}, 4'b1000);
      clr();
      repeat (3) cyc();
      check("t3_mwait_cnt", n_wait, 3);
      check("t3_mwait_wen", n_w, 0);
      cyc();
      check("t3_wb", {b3.w_en, b3.wb_sel}, 3'b101);
      cyc();
      check("t3_fetch2", {b3.w_en, b3.waiting}, 2'b01);

      // Reset mid-MWAIT on a second LDR
      repeat (6) cyc();
      check("t3b_mem", b3.load_addr, 1'b1);
      repeat (2) cyc();
      check("t3b_mwait", b3.waiting, 1'b1);
      #2 rst3_n = 1'b0;
      #1;
      check("t3b_async_rst", {b3.waiting, b3.w_en, b3.ram_w_en, b3.load_addr, b3.clear_pc}, 5'b00001);
      @(negedge clk);
      rst3_n = 1'b1;
      cyc();
      check("t3b_refetch", {b3.waiting, b3.load_addr, b3.sel_addr}, 3'b111);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
